adc_ltc2308_emu: RTL
====================

ADC_LTC2308_EMU -- requirements
Module: adc_ltc2308_emu

Interface
REQ-001 SHALL have parameter TCONV_CYC, default 52: conversion busy time in clk cycles, measured from the detected CONVST rise to the first data bit valid.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; its frequency SHALL be at least 8x the ADC_SCK frequency.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port ADC_CONVST, input, 1 bit: conversion start from the SPI master.
REQ-005 SHALL have port ADC_SCK, input, 1 bit: serial clock from the master.
REQ-006 SHALL have port ADC_SDI, input, 1 bit: 6-bit config word from the master, MSB first.
REQ-007 SHALL have port ADC_SDO, output, 1 bit: 12-bit conversion result, MSB first.
REQ-008 SHALL have port ch_wr, input, 1 bit: write strobe for the channel value table.
REQ-009 SHALL have port ch_addr, input, 3 bits: channel index for ch_wr.
REQ-010 SHALL have port ch_wdata, input, 12 bits: unipolar (straight binary) value for the channel at ch_addr.
REQ-011 SHALL have port busy, output, 1 bit: high while in the CONV state.
REQ-012 SHALL have port cfg_valid, output, 1 bit: one-clk pulse when a full 6-bit config word has been accepted.
REQ-013 SHALL have port cfg_word, output, 6 bits: last accepted config word {S/D, O/S, S1, S0, UNI, SLP}.
REQ-014 SHALL have port frame_count, output, 16 bits: number of completed 12-bit frames; wraps from 0xFFFF to 0.

Function
REQ-015 SHALL pass ADC_CONVST, ADC_SCK and ADC_SDI each through a 2-flop synchronizer, followed by a registered edge detector; all logic SHALL run on posedge clk.
REQ-016 SHALL hold an 8x12-bit channel table; on ch_wr, ch_wdata is written to entry ch_addr on the next clock edge.
REQ-017 SHALL implement states IDLE, CONV, SHIFT.
- IDLE -> CONV: on a detected CONVST rise.
- CONV -> SHIFT: after TCONV_CYC cycles.
- SHIFT -> IDLE: after the 12th SCK fall.
REQ-018 SHALL, on the CONVST rise, snapshot the active channel value into a 12-bit shift register; a table write after the snapshot SHALL NOT affect the current frame.
REQ-019 SHALL derive the active channel from the previously accepted config word as ch = {S1, S0, O/S}.
- Examples: {S/D,O/S,S1,S0} = 0x8 -> ch0, 0xC -> ch1, 0x9 -> ch2, 0xF -> ch7.
- A config word received in frame N SHALL apply to conversion N+1.
REQ-020 SHALL return 12'h000 as snapshot data when the active S/D = 0 (differential mode is not emulated).
REQ-021 SHALL convert the snapshot to two's complement (invert bit 11) when the active UNI = 0.
REQ-022 SHALL drive snapshot bit 11 onto ADC_SDO on the CONV -> SHIFT transition, and shift out the next bit on each detected SCK fall.
REQ-023 SHALL drive ADC_SDO = 0 in IDLE, in CONV, and after bit 0 has been shifted out.
REQ-024 SHALL update ADC_SDO no later than 4 clk cycles after the SCK pin falls.
REQ-025 SHALL sample synchronized SDI on each of the first 6 detected SCK rises in SHIFT.
- On the 6th rise: update cfg_word and pulse cfg_valid for one clk.
REQ-026 SHALL discard a partial config word (fewer than 6 rises) and leave cfg_word unchanged.
REQ-027 SHALL increment frame_count on the 12th SCK fall.
REQ-028 SHALL ignore a CONVST rise while in CONV.
REQ-029 SHALL, on a CONVST rise in SHIFT, abort the frame and take a new snapshot.
- The partial config is discarded and frame_count is not incremented.
- The state SHALL enter CONV.
REQ-030 SHALL ignore SCK edges in IDLE and CONV.
REQ-031 SHALL ignore SCK edges in SHIFT beyond the 12th fall.
REQ-032 SHALL record SLP in cfg_word only; it SHALL have no other effect.

Reset
REQ-033 SHALL, while reset is high, force the following values:
- state = IDLE; ADC_SDO = 0; busy = 0; cfg_valid = 0.
- cfg_word = 6'b100010 (ch0, unipolar); frame_count = 0.
- All synchronizer and edge-detector flops = 0; all channel table entries = 0.
REQ-034 SHALL, when reset asserts mid-frame, abandon the frame immediately; the first CONVST rise after reset SHALL start a clean frame using ch0 unipolar.

Verification
REQ-035 Basic read: table[0] = 0xA5C, default config, CONVST pulse, 12 SCK -> SDO bits read 1010_0101_1100, frame_count = 1, busy high for exactly TCONV_CYC clk.
REQ-036 Config pipelining: frame 1 sends 0xC/1/0 while table[1] = 0x123 -> frame 1 data = ch0 value, cfg_valid pulses once with cfg_word = 6'b110010, frame 2 data = 0x123.
REQ-037 Bipolar: config UNI = 0 for ch2, table[2] = 0x800 -> next frame returns 0x000; table[2] = 0x7FF -> returns 0xFFF.
REQ-038 Abort: CONVST rise after 7 SCK falls -> frame_count unchanged, busy reasserts, new full frame returns the current table value; a second CONVST rise during CONV has no effect.
REQ-039 Snapshot/reset: write table[0] = 0xFFF one clk after the CONVST rise -> frame returns the old value; assert reset mid-SHIFT -> SDO = 0 and cfg_word = 6'b100010 immediately.
REQ-040 Back-to-back at the master's 100 kHz rate, 1000 frames with random channels and values -> every result matches the expected value; frame_count = 1000.

Source files
------------

// File: rtl/adc_ltc2308_emu.sv
// LTC2308 ADC emulator: SPI slave that returns values from a writable
// channel table, with config-word pipelining as in the real part.
module adc_ltc2308_emu #(
  parameter int TCONV_CYC = 52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCK,
  input  logic        ADC_SDI,
  output logic        ADC_SDO,
  input  logic        ch_wr,
  input  logic [2:0]  ch_addr,
  input  logic [11:0] ch_wdata,
  output logic        busy,
  output logic        cfg_valid,
  output logic [5:0]  cfg_word,
  output logic [15:0] frame_count
);

  localparam int CW = (TCONV_CYC > 1) ? $clog2(TCONV_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic cs_s1, cs_s2, cs_d;
  logic sck_s1, sck_s2, sck_d;
  logic sdi_s1, sdi_s2;
  logic cs_rise, sck_rise, sck_fall;

  logic [11:0]   tbl [8];
  logic [11:0]   shreg;
  logic [11:0]   raw;
  logic [11:0]   snap;
  logic [2:0]    ch;
  logic [CW-1:0] conv_cnt;
  logic [3:0]    fall_cnt;
  logic [2:0]    rise_cnt;
  logic [4:0]    cfg_sh;
  logic          conv_done;
  logic          last_fall;
  logic          start;

  assign cs_rise  = cs_s2 & ~cs_d;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;

  assign conv_done = (conv_cnt == CW'(TCONV_CYC - 1));
  assign last_fall = sck_fall && (fall_cnt == 4'd11);
  assign start     = cs_rise && (state != CONV);

  // Active channel comes from the previously accepted word: {S1, S0, O/S}
  assign ch  = {cfg_word[3], cfg_word[2], cfg_word[4]};
  assign raw = tbl[ch];

  always_comb begin
    snap = raw;
    if (!cfg_word[5]) begin
      snap = 12'h000;
    end else if (!cfg_word[1]) begin
      snap = {~raw[11], raw[10:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cs_rise) state_nx = CONV;
      end
      CONV: begin
        if (conv_done) state_nx = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx = CONV;
        end else if (last_fall) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1  <= 1'b0;
      cs_s2  <= 1'b0;
      cs_d   <= 1'b0;
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      cs_s1  <= ADC_CONVST;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      sck_s1 <= ADC_SCK;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      sdi_s1 <= ADC_SDI;
      sdi_s2 <= sdi_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        tbl[i] <= '0;
      end
    end else if (ch_wr) begin
      tbl[ch_addr] <= ch_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      conv_cnt    <= '0;
      fall_cnt    <= '0;
      rise_cnt    <= '0;
      cfg_sh      <= '0;
      cfg_valid   <= 1'b0;
      cfg_word    <= 6'b100010;
      frame_count <= '0;
    end else begin
      cfg_valid <= 1'b0;
      if (start) begin
        // New or aborted frame: drop any partial config word
        shreg    <= snap;
        conv_cnt <= '0;
        fall_cnt <= '0;
        rise_cnt <= '0;
      end else if (state == CONV) begin
        conv_cnt <= conv_cnt + 1'b1;
      end else if (state == SHIFT) begin
        if (sck_fall) begin
          shreg    <= {shreg[10:0], 1'b0};
          fall_cnt <= fall_cnt + 1'b1;
          if (last_fall) frame_count <= frame_count + 1'b1;
        end
        if (sck_rise && (rise_cnt < 3'd6)) begin
          cfg_sh   <= {cfg_sh[3:0], sdi_s2};
          rise_cnt <= rise_cnt + 1'b1;
          if (rise_cnt == 3'd5) begin
            cfg_word  <= {cfg_sh, sdi_s2};
            cfg_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign busy    = (state == CONV);
  assign ADC_SDO = (state == SHIFT) & shreg[11];

endmodule
